// File: rtl/i2c_config_seq.sv
// I2C configuration sequencer: after a power-up delay it walks a LUT of
// {dev_addr, reg_addr, wr_data} entries and issues one I2C write per entry, retrying NACKs.
module i2c_config_seq #(
    parameter int          IDX_W        = 8,
    parameter logic [15:0] DELAY_CYCLES = 16'd1000,
    parameter int          MAX_RETRY    = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_start,
    input  logic [IDX_W-1:0] lut_size,
    output logic [IDX_W-1:0] lut_index,
    input  logic [31:0]      lut_data,
    output logic             i2c_write_req,
    input  logic             i2c_write_req_ack,
    input  logic             i2c_error,
    output logic [7:0]       i2c_slave_dev_addr,
    output logic [15:0]      i2c_slave_reg_addr,
    output logic [7:0]       i2c_write_data,
    output logic             cfg_busy,
    output logic             cfg_done,
    output logic             cfg_fail,
    output logic [IDX_W-1:0] fail_index
);

    localparam int                 RETRY_W     = $clog2(MAX_RETRY + 2);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRY);

    typedef enum logic [2:0] {
        IDLE,
        DELAY,
        LOAD,
        REQ,
        CHECK,
        NEXT,
        DONE,
        FAIL
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [RETRY_W-1:0] retry_cnt;
    logic [RETRY_W-1:0] retry_cnt_nxt;
    logic [15:0]        delay_cnt;
    logic [15:0]        delay_cnt_nxt;
    logic               load_phase;
    logic               load_phase_nxt;
    logic               err_q;
    logic               err_nxt;
    logic [IDX_W-1:0]   lut_index_nxt;
    logic               write_req_nxt;
    logic [7:0]         dev_addr_nxt;
    logic [15:0]        reg_addr_nxt;
    logic [7:0]         write_data_nxt;
    logic               busy_nxt;
    logic               done_nxt;
    logic               fail_nxt;
    logic [IDX_W-1:0]   fail_index_nxt;

    logic delay_last;
    logic last_entry;

    // A zero delay still spends one cycle in DELAY; lut_size is re-read live at every NEXT.
    assign delay_last = (DELAY_CYCLES == 16'd0) || (delay_cnt == DELAY_CYCLES - 16'd1);
    assign last_entry = (lut_size == '0) || (lut_index >= lut_size - IDX_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= IDLE;
            lut_index          <= '0;
            retry_cnt          <= '0;
            delay_cnt          <= '0;
            load_phase         <= 1'b0;
            err_q              <= 1'b0;
            i2c_write_req      <= 1'b0;
            i2c_slave_dev_addr <= '0;
            i2c_slave_reg_addr <= '0;
            i2c_write_data     <= '0;
            cfg_busy           <= 1'b0;
            cfg_done           <= 1'b0;
            cfg_fail           <= 1'b0;
            fail_index         <= '0;
        end else begin
            state              <= state_nxt;
            lut_index          <= lut_index_nxt;
            retry_cnt          <= retry_cnt_nxt;
            delay_cnt          <= delay_cnt_nxt;
            load_phase         <= load_phase_nxt;
            err_q              <= err_nxt;
            i2c_write_req      <= write_req_nxt;
            i2c_slave_dev_addr <= dev_addr_nxt;
            i2c_slave_reg_addr <= reg_addr_nxt;
            i2c_write_data     <= write_data_nxt;
            cfg_busy           <= busy_nxt;
            cfg_done           <= done_nxt;
            cfg_fail           <= fail_nxt;
            fail_index         <= fail_index_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cfg_start) state_nxt = DELAY;
            DELAY:   if (delay_last) state_nxt = (lut_size == '0) ? DONE : LOAD;
            LOAD:    if (load_phase) state_nxt = REQ;
            REQ:     if (i2c_write_req_ack) state_nxt = CHECK;
            CHECK: begin
                if (!err_q)                      state_nxt = NEXT;
                else if (retry_cnt < RETRY_LIMIT) state_nxt = LOAD;
                else                             state_nxt = FAIL;
            end
            NEXT:    state_nxt = last_entry ? DONE : LOAD;
            DONE:    state_nxt = IDLE;
            FAIL:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Request and busy follow the next state so they line up exactly with REQ / non-IDLE.
    always_comb begin
        lut_index_nxt  = lut_index;
        retry_cnt_nxt  = retry_cnt;
        delay_cnt_nxt  = delay_cnt;
        load_phase_nxt = 1'b0;
        err_nxt        = err_q;
        dev_addr_nxt   = i2c_slave_dev_addr;
        reg_addr_nxt   = i2c_slave_reg_addr;
        write_data_nxt = i2c_write_data;
        done_nxt       = cfg_done;
        fail_nxt       = cfg_fail;
        fail_index_nxt = fail_index;
        case (state)
            IDLE: begin
                if (cfg_start) begin
                    done_nxt      = 1'b0;
                    fail_nxt      = 1'b0;
                    lut_index_nxt = '0;
                    retry_cnt_nxt = '0;
                    delay_cnt_nxt = '0;
                end
            end
            DELAY: delay_cnt_nxt = delay_cnt + 16'd1;
            LOAD: begin
                load_phase_nxt = ~load_phase;
                if (load_phase) begin
                    dev_addr_nxt   = lut_data[31:24];
                    reg_addr_nxt   = lut_data[23:8];
                    write_data_nxt = lut_data[7:0];
                end
            end
            REQ: if (i2c_write_req_ack) err_nxt = i2c_error;
            CHECK: begin
                if (err_q) begin
                    if (retry_cnt < RETRY_LIMIT) begin
                        retry_cnt_nxt = retry_cnt + RETRY_W'(1);
                    end else begin
                        fail_index_nxt = lut_index;
                        fail_nxt       = 1'b1;
                    end
                end
            end
            NEXT: begin
                if (!last_entry) begin
                    lut_index_nxt = lut_index + IDX_W'(1);
                    retry_cnt_nxt = '0;
                end
            end
            DONE:    done_nxt = 1'b1;
            FAIL:    fail_nxt = 1'b1;
            default: ;
        endcase
        write_req_nxt = (state_nxt == REQ);
        busy_nxt      = (state_nxt != IDLE);
    end

endmodule

// File: tb/tb_i2c_config_seq.sv
// Self-checking bench for i2c_config_seq: LUT ROM and I2C master models drive the DUT,
// a write monitor collects attempts, and a list-based model predicts each run.
module tb_i2c_config_seq;

    localparam int D         = 4;
    localparam int MAX_RETRY = 2;
    localparam int ALWAYS    = 255;

    typedef struct packed {
        logic [7:0]  idx;
        logic [31:0] fields;
    } wr_t;

    logic        clk;
    logic        rst_n;
    logic        cfg_start;
    logic [7:0]  lut_size;
    logic [7:0]  lut_index;
    logic [31:0] lut_data;
    logic        i2c_write_req;
    logic        i2c_write_req_ack;
    logic        i2c_error;
    logic [7:0]  i2c_slave_dev_addr;
    logic [15:0] i2c_slave_reg_addr;
    logic [7:0]  i2c_write_data;
    logic        cfg_busy;
    logic        cfg_done;
    logic        cfg_fail;
    logic [7:0]  fail_index;

    int vectors;
    int miscompares;

    logic [31:0] lut_mem [256];
    int          nack_plan [256];
    int          tries [256];
    int          ack_delay;
    bit          stray_en;

    wr_t got[$];
    wr_t exp_q[$];
    bit  exp_fail;
    int  exp_fidx;

    i2c_config_seq #(
        .IDX_W       (8),
        .DELAY_CYCLES(16'd4),
        .MAX_RETRY   (MAX_RETRY)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .cfg_start         (cfg_start),
        .lut_size          (lut_size),
        .lut_index         (lut_index),
        .lut_data          (lut_data),
        .i2c_write_req     (i2c_write_req),
        .i2c_write_req_ack (i2c_write_req_ack),
        .i2c_error         (i2c_error),
        .i2c_slave_dev_addr(i2c_slave_dev_addr),
        .i2c_slave_reg_addr(i2c_slave_reg_addr),
        .i2c_write_data    (i2c_write_data),
        .cfg_busy          (cfg_busy),
        .cfg_done          (cfg_done),
        .cfg_fail          (cfg_fail),
        .fail_index        (fail_index)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous LUT: data reflects the index presented at the previous edge.
    always @(posedge clk) lut_data <= lut_mem[lut_index];

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // I2C master: acks ack_delay cycles into a request, NACKing per the plan for that index.
    initial begin
        int wait_cnt;
        wait_cnt          = 0;
        i2c_write_req_ack = 1'b0;
        i2c_error         = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            i2c_write_req_ack = 1'b0;
            i2c_error         = 1'b0;
            if (!i2c_write_req) begin
                wait_cnt = 0;
                if (stray_en && $urandom_range(0, 7) == 0) begin
                    i2c_write_req_ack = 1'b1;
                    i2c_error         = 1'($urandom_range(0, 1));
                end
            end else begin
                wait_cnt++;
                if (wait_cnt >= ack_delay) begin
                    i2c_write_req_ack = 1'b1;
                    i2c_error         = (tries[lut_index] < nack_plan[lut_index]);
                    tries[lut_index]++;
                    wait_cnt = 0;
                end
            end
        end
    end

    // Monitor: one record per request rising edge, fields held, req low after each ack.
    initial begin
        bit          prev_req;
        bit          ack_prev;
        logic [31:0] held;
        logic [31:0] cur;
        wr_t         w;
        prev_req = 1'b0;
        ack_prev = 1'b0;
        held     = '0;
        forever begin
            @(negedge clk);
            if (ack_prev) checkOutput("req_low_after_ack", 32'(i2c_write_req), 32'd0);
            ack_prev = i2c_write_req && i2c_write_req_ack;
            cur = {i2c_slave_dev_addr, i2c_slave_reg_addr, i2c_write_data};
            if (i2c_write_req && !prev_req) begin
                w.idx    = lut_index;
                w.fields = cur;
                got.push_back(w);
                held = cur;
            end else if (i2c_write_req) begin
                checkOutput("fields_stable", cur, held);
            end
            prev_req = i2c_write_req;
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic clearPlan();
        for (int i = 0; i < 256; i++) begin
            nack_plan[i] = 0;
            tries[i]     = 0;
        end
    endtask

    // Reference: entries in order; each gets min(nacks, MAX_RETRY)+1 attempts; overflowing nacks stop the run.
    task automatic buildModel(input int size);
        wr_t w;
        exp_q.delete();
        exp_fail = 1'b0;
        exp_fidx = 0;
        for (int i = 0; i < size; i++) begin
            int attempts;
            attempts = (nack_plan[i] > MAX_RETRY) ? MAX_RETRY + 1 : nack_plan[i] + 1;
            for (int a = 0; a < attempts; a++) begin
                w.idx    = 8'(i);
                w.fields = lut_mem[i];
                exp_q.push_back(w);
            end
            if (nack_plan[i] > MAX_RETRY) begin
                exp_fail = 1'b1;
                exp_fidx = i;
                break;
            end
        end
    endtask

    task automatic applyStimulus(input int size, input int delay, input bit poke);
        int cycles;
        got.delete();
        for (int i = 0; i < 256; i++) tries[i] = 0;
        buildModel(size);
        ack_delay = delay;
        lut_size  = 8'(size);
        @(posedge clk);
        #2 cfg_start = 1'b1;
        @(posedge clk);
        #2 cfg_start = 1'b0;
        cycles = 0;
        while (cfg_busy && cycles < 3000) begin
            @(posedge clk);
            #2;
            cycles++;
            cfg_start = poke && i2c_write_req && ($urandom_range(0, 1) == 1);
        end
        cfg_start = 1'b0;
        checkOutput("run_terminates", 32'(cfg_busy), 32'd0);
    endtask

    task automatic checkRun(input string name);
        checkOutput({name, ":write_count"}, 32'(got.size()), 32'(exp_q.size()));
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            checkOutput({name, ":write_idx"}, 32'(got[i].idx), 32'(exp_q[i].idx));
            checkOutput({name, ":write_fields"}, got[i].fields, exp_q[i].fields);
        end
        checkOutput({name, ":done"}, 32'(cfg_done), 32'(!exp_fail));
        checkOutput({name, ":fail"}, 32'(cfg_fail), 32'(exp_fail));
        if (exp_fail) checkOutput({name, ":fail_index"}, 32'(fail_index), 32'(exp_fidx));
    endtask

    task automatic checkAllZero(input string name);
        checkOutput({name, ":req"}, 32'(i2c_write_req), 32'd0);
        checkOutput({name, ":busy"}, 32'(cfg_busy), 32'd0);
        checkOutput({name, ":done"}, 32'(cfg_done), 32'd0);
        checkOutput({name, ":fail"}, 32'(cfg_fail), 32'd0);
        checkOutput({name, ":index"}, 32'(lut_index), 32'd0);
        checkOutput({name, ":fail_index"}, 32'(fail_index), 32'd0);
        checkOutput({name, ":fields"}, {i2c_slave_dev_addr, i2c_slave_reg_addr, i2c_write_data}, 32'd0);
    endtask

    initial begin
        int cycles;
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b1;
        cfg_start   = 1'b0;
        lut_size    = '0;
        ack_delay   = 20;
        stray_en    = 1'b0;
        clearPlan();
        for (int i = 0; i < 256; i++) lut_mem[i] = $urandom;

        #3 rst_n = 1'b0;
        #1 checkAllZero("reset");
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        $display("[TB] normal run");
        lut_mem[0] = {8'h78, 16'h3008, 8'h82};
        lut_mem[1] = {8'h78, 16'h3103, 8'h11};
        lut_mem[2] = {8'h78, 16'h3017, 8'h00};
        applyStimulus(3, 20, 1'b0);
        checkRun("normal");

        $display("[TB] empty LUT");
        got.delete();
        lut_size = '0;
        @(posedge clk);
        #2 cfg_start = 1'b1;
        @(posedge clk);
        #2 cfg_start = 1'b0;
        for (int k = 1; k <= D + 2; k++) begin
            @(negedge clk);
            checkOutput("empty:done", 32'(cfg_done), 32'(k == D + 2));
            checkOutput("empty:busy", 32'(cfg_busy), 32'(k < D + 2));
        end
        checkOutput("empty:no_write", 32'(got.size()), 32'd0);

        $display("[TB] retry then succeed");
        clearPlan();
        nack_plan[1] = 1;
        applyStimulus(3, 3, 1'b0);
        checkRun("retry");

        $display("[TB] retry exhaustion");
        clearPlan();
        nack_plan[2] = ALWAYS;
        applyStimulus(4, 2, 1'b0);
        checkRun("exhaust");
        checkOutput("exhaust:index_stops", 32'(lut_index), 32'd2);

        $display("[TB] start while busy");
        clearPlan();
        applyStimulus(4, 3, 1'b1);
        checkRun("busy_start");

        $display("[TB] randomized runs");
        stray_en = 1'b1;
        for (int r = 0; r < 6; r++) begin
            int size;
            clearPlan();
            size = $urandom_range(1, 6);
            for (int i = 0; i < 8; i++) begin
                int v;
                lut_mem[i] = $urandom;
                v = $urandom_range(0, 11);
                nack_plan[i] = (v < 7) ? 0 : (v == 7) ? 1 : (v == 8) ? 2 : (v == 9) ? 3 : (v == 10) ? 1 : ALWAYS;
            end
            applyStimulus(size, $urandom_range(1, 5), 1'b0);
            checkRun("random");
        end
        stray_en = 1'b0;

        $display("[TB] reset mid-run");
        clearPlan();
        ack_delay = 10;
        lut_size  = 8'd3;
        @(posedge clk);
        #2 cfg_start = 1'b1;
        @(posedge clk);
        #2 cfg_start = 1'b0;
        cycles = 0;
        while (!(i2c_write_req && lut_index == 8'd1) && cycles < 500) begin
            @(posedge clk);
            #2;
            cycles++;
        end
        checkOutput("midrst:reached_entry1", 32'(lut_index), 32'd1);
        rst_n = 1'b0;
        #1 checkAllZero("midrst");
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checkOutput("midrst:idle_req", 32'(i2c_write_req), 32'd0);
            checkOutput("midrst:idle_busy", 32'(cfg_busy), 32'd0);
        end
        applyStimulus(3, 3, 1'b0);
        checkRun("after_reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
